vending_controller: RTL and testbench

Clocked, parametrised successor to the event-driven vending machine. It accumulates coin credit, checks selections against a per-slot price and stock table, and hands off a vend request. It then pays out change one coin per handshake using greedy denominations. It sits between the debounced button/coin-acceptor front end and the slot motors, coin hopper and the 7-segment formatter.

---
 rtl/vending_controller.sv | 275 +++++++++++++++++++++++++++
 tb/tb_vending_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_controller.sv
// Vending controller: coin credit, price/stock table, vend handshake and greedy change payout.
// Optional idle auto-return of credit is enabled by defining VENDING_AUTO_RETURN_EN.
module vending_controller #(
  parameter int unsigned NUM_ITEMS   = 9,
  parameter int unsigned CREDIT_W    = 10,
  parameter int unsigned MAX_CREDIT  = 500,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned INIT_STOCK  = 5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [2:0]          coin_sel,
  input  logic                sel_valid,
  input  logic [3:0]          sel_idx,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_idx,
  input  logic [CREDIT_W-1:0] cfg_price,
  input  logic [STOCK_W-1:0]  cfg_stock,
  output logic                vend_valid,
  output logic [3:0]          vend_idx,
  input  logic                vend_ready,
  output logic                chg_valid,
  output logic [2:0]          chg_sel,
  input  logic                chg_ready,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] disp_val,
  output logic                disp_neg,
  output logic [NUM_ITEMS-1:0] avail,
  output logic [NUM_ITEMS-1:0] oos,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  function automatic logic [CREDIT_W-1:0] default_price(input int unsigned i);
    int unsigned p;
    case (i)
      0:       p = 100;
      2:       p = 125;
      3:       p = 175;
      4:       p = 225;
      5:       p = 250;
      6:       p = 100;
      7:       p = 325;
      8:       p = 375;
      default: p = 0;
    endcase
    return CREDIT_W'(p);
  endfunction

  function automatic logic [CREDIT_W:0] coin_value(input logic [2:0] c);
    case (c)
      3'd0:    return (CREDIT_W+1)'(5);
      3'd1:    return (CREDIT_W+1)'(10);
      3'd2:    return (CREDIT_W+1)'(25);
      3'd3:    return (CREDIT_W+1)'(50);
      3'd4:    return (CREDIT_W+1)'(100);
      3'd5:    return (CREDIT_W+1)'(500);
      default: return '0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] disp_val_q, disp_val_d;
  logic                disp_neg_q, disp_neg_d;
  logic                coin_reject_q, coin_reject_d;
  logic [3:0]          vend_idx_q, vend_idx_d;

  logic [CREDIT_W-1:0] price_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];

  logic                cfg_wr;
  logic                stock_dec;
  logic                coin_acc;
  logic                cancel_evt;
  logic                timeout_hit;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                sel_in_range;
  logic                cfg_in_range;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_oos;
  logic [2:0]          chg_code;
  logic [CREDIT_W-1:0] chg_amt;
  logic                chg_can_pay;

  assign coin_sum     = {1'b0, credit_q} + coin_value(coin_sel);
  assign coin_ok      = (coin_sel <= 3'd5) && (coin_sum <= MAX_C);
  assign sel_in_range = 32'(sel_idx) < NUM_ITEMS;
  assign cfg_in_range = 32'(cfg_idx) < NUM_ITEMS;
  assign sel_price    = sel_in_range ? price_q[sel_idx] : '0;
  assign sel_oos      = sel_in_range ? ((price_q[sel_idx] == '0) || (stock_q[sel_idx] == '0)) : 1'b1;
  assign cancel_evt   = cancel || timeout_hit;

  always_comb begin
    avail = '0;
    oos   = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      oos[i]   = (price_q[i] == '0) || (stock_q[i] == '0);
      avail[i] = !oos[i] && (credit_q >= price_q[i]);
    end
  end

  // Greedy change: largest denomination not exceeding the remaining credit.
  always_comb begin
    chg_code    = 3'd0;
    chg_amt     = '0;
    chg_can_pay = 1'b1;
    if (credit_q >= CREDIT_W'(100)) begin
      chg_code = 3'd4;
      chg_amt  = CREDIT_W'(100);
    end else if (credit_q >= CREDIT_W'(50)) begin
      chg_code = 3'd3;
      chg_amt  = CREDIT_W'(50);
    end else if (credit_q >= CREDIT_W'(25)) begin
      chg_code = 3'd2;
      chg_amt  = CREDIT_W'(25);
    end else if (credit_q >= CREDIT_W'(10)) begin
      chg_code = 3'd1;
      chg_amt  = CREDIT_W'(10);
    end else if (credit_q >= CREDIT_W'(5)) begin
      chg_code = 3'd0;
      chg_amt  = CREDIT_W'(5);
    end else begin
      chg_can_pay = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_val_d    = disp_val_q;
    disp_neg_d    = disp_neg_q;
    vend_idx_d    = vend_idx_q;
    coin_reject_d = 1'b0;
    cfg_wr        = 1'b0;
    stock_dec     = 1'b0;
    coin_acc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cancel_evt) begin
          if (credit_q != '0) begin
            disp_val_d = credit_q;
            disp_neg_d = 1'b0;
            state_d    = S_CHANGE;
          end
        end else if (sel_valid) begin
          if (sel_in_range) begin
            if (credit_q == '0 || sel_oos) begin
              disp_val_d = sel_price;
              disp_neg_d = 1'b0;
            end else if (credit_q < sel_price) begin
              disp_val_d = sel_price - credit_q;
              disp_neg_d = 1'b1;
            end else begin
              credit_d   = credit_q - sel_price;
              disp_val_d = credit_q - sel_price;
              disp_neg_d = 1'b0;
              vend_idx_d = sel_idx;
              state_d    = S_VEND;
            end
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            coin_acc   = 1'b1;
            credit_d   = coin_sum[CREDIT_W-1:0];
            disp_val_d = coin_sum[CREDIT_W-1:0];
            disp_neg_d = 1'b0;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        if (coin_valid && (cancel_evt || sel_valid)) coin_reject_d = 1'b1;
        if (cfg_we && cfg_in_range && credit_q == '0) cfg_wr = 1'b1;
      end
      S_VEND: begin
        if (coin_valid) coin_reject_d = 1'b1;
        if (vend_ready) begin
          stock_dec = 1'b1;
          state_d   = (credit_q != '0) ? S_CHANGE : S_IDLE;
        end
      end
      S_CHANGE: begin
        if (coin_valid) coin_reject_d = 1'b1;
        // A sub-5c residue (odd configured price) cannot be paid out and is dropped.
        if (!chg_can_pay) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end else if (chg_ready) begin
          credit_d = credit_q - chg_amt;
          if (credit_q == chg_amt) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      disp_val_q    <= '0;
      disp_neg_q    <= 1'b0;
      coin_reject_q <= 1'b0;
      vend_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_val_q    <= disp_val_d;
      disp_neg_q    <= disp_neg_d;
      coin_reject_q <= coin_reject_d;
      vend_idx_q    <= vend_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        price_q[i] <= default_price(i);
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      if (cfg_wr) begin
        price_q[cfg_idx] <= cfg_price;
        stock_q[cfg_idx] <= cfg_stock;
      end
      if (stock_dec && stock_q[vend_idx_q] != '0) begin
        stock_q[vend_idx_q] <= stock_q[vend_idx_q] - STOCK_W'(1);
      end
    end
  end

`ifdef VENDING_AUTO_RETURN_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  assign timeout_hit = (state_q == S_IDLE) && (credit_q != '0) &&
                       (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmr_d = tmr_q + TMR_W'(1);
    if (state_q != S_IDLE || credit_q == '0 || coin_acc || sel_valid) tmr_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign vend_valid  = (state_q == S_VEND);
  assign vend_idx    = vend_idx_q;
  assign chg_valid   = (state_q == S_CHANGE) && chg_can_pay;
  assign chg_sel     = chg_code;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign disp_val    = disp_val_q;
  assign disp_neg    = disp_neg_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench for vending_controller: expected vends/change coins queued at stimulus, checked at handshake.
module tb_vending_controller;

  localparam int unsigned N  = 9;
  localparam int unsigned CW = 10;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coin_valid = 1'b0;
  logic [2:0]    coin_sel = '0;
  logic          sel_valid = 1'b0;
  logic [3:0]    sel_idx = '0;
  logic          cancel = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_idx = '0;
  logic [CW-1:0] cfg_price = '0;
  logic [SW-1:0] cfg_stock = '0;
  logic          vend_valid;
  logic [3:0]    vend_idx;
  logic          vend_ready = 1'b1;
  logic          chg_valid;
  logic [2:0]    chg_sel;
  logic          chg_ready = 1'b1;
  logic          coin_reject;
  logic [CW-1:0] credit;
  logic [CW-1:0] disp_val;
  logic          disp_neg;
  logic [N-1:0]  avail;
  logic [N-1:0]  oos;
  logic          busy;

  vending_controller #(
    .NUM_ITEMS(N), .CREDIT_W(CW), .MAX_CREDIT(500), .STOCK_W(SW),
    .INIT_STOCK(5), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
    .vend_valid(vend_valid), .vend_idx(vend_idx), .vend_ready(vend_ready),
    .chg_valid(chg_valid), .chg_sel(chg_sel), .chg_ready(chg_ready),
    .coin_reject(coin_reject), .credit(credit), .disp_val(disp_val),
    .disp_neg(disp_neg), .avail(avail), .oos(oos), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_vend_q[$];
  int exp_chg_q[$];
  int e_v, e_c;

  // Handshakes are observed on the falling edge, where inputs and outputs are both settled.
  always @(negedge clk) begin
    if (rst_n && vend_valid && vend_ready) begin
      n_tests++;
      if (exp_vend_q.size() == 0) begin
        n_fail++;
        $display("FAIL vend_unexpected: vend_idx=%0d, required no vend", vend_idx);
      end else begin
        e_v = exp_vend_q.pop_front();
        if (vend_idx !== 4'(e_v)) begin
          n_fail++;
          $display("FAIL vend_idx: got %0d, expected %0d", vend_idx, e_v);
        end
      end
    end
    if (rst_n && chg_valid && chg_ready) begin
      n_tests++;
      if (exp_chg_q.size() == 0) begin
        n_fail++;
        $display("FAIL chg_unexpected: chg_sel=%0d, required no coin", chg_sel);
      end else begin
        e_c = exp_chg_q.pop_front();
        if (chg_sel !== 3'(e_c)) begin
          n_fail++;
          $display("FAIL chg_sel: got %0d, expected %0d", chg_sel, e_c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [2:0] c);
    coin_valid = 1'b1;
    coin_sel   = c;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [3:0] i);
    sel_valid = 1'b1;
    sel_idx   = i;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_tests++; if (credit !== '0)        begin n_fail++; $display("FAIL rst_credit: got %0d, expected 0", credit); end
    n_tests++; if (disp_val !== '0)      begin n_fail++; $display("FAIL rst_disp: got %0d, expected 0", disp_val); end
    n_tests++; if ({vend_valid, chg_valid, coin_reject, busy, disp_neg} !== 5'b0)
      begin n_fail++; $display("FAIL rst_flags: got %b, expected 00000", {vend_valid, chg_valid, coin_reject, busy, disp_neg}); end
    n_tests++; if (oos !== 9'b000000010) begin n_fail++; $display("FAIL rst_oos: got %b, expected 000000010", oos); end
    n_tests++; if (avail !== '0)         begin n_fail++; $display("FAIL rst_avail: got %b, expected 0", avail); end
    rst_n = 1'b1;
    tick();
    sel(4'd0);
    n_tests++; if (disp_val !== 10'd100 || disp_neg !== 1'b0)
      begin n_fail++; $display("FAIL sel_zero_credit: got disp %0d neg %b, expected 100 neg 0", disp_val, disp_neg); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sel_zero_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_vend();
    int hi;
    coin(3'd4); coin(3'd2); coin(3'd2);
    n_tests++; if (credit !== 10'd150) begin n_fail++; $display("FAIL vend_credit_in: got %0d, expected 150", credit); end
    vend_ready = 1'b0;
    exp_vend_q.push_back(2);
    exp_chg_q.push_back(2);
    sel(4'd2);
    n_tests++; if (vend_idx !== 4'd2 || credit !== 10'd25 || disp_val !== 10'd25)
      begin n_fail++; $display("FAIL vend_start: got idx %0d credit %0d disp %0d, expected 2 25 25", vend_idx, credit, disp_val); end
    hi = 0;
    repeat (3) begin
      if (vend_valid) hi++;
      tick();
    end
    n_tests++; if (hi != 3) begin n_fail++; $display("FAIL vend_hold: got %0d cycles, expected 3", hi); end
    vend_ready = 1'b1;
    wait_idle(50);
    n_tests++; if (busy !== 1'b0 || credit !== '0)
      begin n_fail++; $display("FAIL vend_done: got busy %b credit %0d, expected 0 0", busy, credit); end
    n_tests++; if (dut.stock_q[2] !== 4'd4) begin n_fail++; $display("FAIL vend_stock: got %0d, expected 4", dut.stock_q[2]); end
    n_tests++; if (disp_val !== 10'd25) begin n_fail++; $display("FAIL vend_disp_kept: got %0d, expected 25", disp_val); end
    n_tests++; if (exp_vend_q.size() != 0 || exp_chg_q.size() != 0)
      begin n_fail++; $display("FAIL vend_sb_drain: got %0d/%0d left, expected 0/0", exp_vend_q.size(), exp_chg_q.size()); end
  endtask

  task automatic test_max_credit();
    coin(3'd6);
    n_tests++; if (coin_reject !== 1'b1 || credit !== '0)
      begin n_fail++; $display("FAIL invalid_coin: got rej %b credit %0d, expected 1 0", coin_reject, credit); end
    coin(3'd5);
    n_tests++; if (coin_reject !== 1'b0 || credit !== 10'd500)
      begin n_fail++; $display("FAIL coin_500: got rej %b credit %0d, expected 0 500", coin_reject, credit); end
    coin(3'd0);
    n_tests++; if (coin_reject !== 1'b1 || credit !== 10'd500)
      begin n_fail++; $display("FAIL over_max: got rej %b credit %0d, expected 1 500", coin_reject, credit); end
    tick();
    n_tests++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL rej_pulse: got %b, expected 0", coin_reject); end
    repeat (5) exp_chg_q.push_back(4);
    do_cancel();
    n_tests++; if (busy !== 1'b1 || disp_val !== 10'd500)
      begin n_fail++; $display("FAIL cancel_start: got busy %b disp %0d, expected 1 500", busy, disp_val); end
    wait_idle(50);
    n_tests++; if (busy !== 1'b0 || credit !== '0 || exp_chg_q.size() != 0)
      begin n_fail++; $display("FAIL cancel_done: got busy %b credit %0d left %0d, expected 0 0 0", busy, credit, exp_chg_q.size()); end
  endtask

  task automatic test_shortfall();
    coin(3'd4);
    n_tests++; if (avail !== 9'b001000001) begin n_fail++; $display("FAIL avail_100: got %b, expected 001000001", avail); end
    sel(4'd7);
    n_tests++; if (disp_val !== 10'd225 || disp_neg !== 1'b1 || busy !== 1'b0 || credit !== 10'd100)
      begin n_fail++; $display("FAIL shortfall: got disp %0d neg %b busy %b credit %0d, expected 225 1 0 100", disp_val, disp_neg, busy, credit); end
    sel(4'd12);
    n_tests++; if (disp_val !== 10'd225 || busy !== 1'b0)
      begin n_fail++; $display("FAIL sel_out_of_range: got disp %0d busy %b, expected 225 0", disp_val, busy); end
    sel(4'd1);
    n_tests++; if (disp_val !== '0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL sel_oos: got disp %0d busy %b, expected 0 0", disp_val, busy); end
    exp_chg_q.push_back(4);
    do_cancel();
    wait_idle(50);
    n_tests++; if (credit !== '0 || exp_chg_q.size() != 0)
      begin n_fail++; $display("FAIL shortfall_return: got credit %0d left %0d, expected 0 0", credit, exp_chg_q.size()); end
  endtask

  task automatic test_cancel_coin();
    coin(3'd3);
    chg_ready = 1'b0;
    exp_chg_q.push_back(3);
    cancel = 1'b1; coin_valid = 1'b1; coin_sel = 3'd1;
    tick();
    cancel = 1'b0; coin_valid = 1'b0;
    n_tests++; if (coin_reject !== 1'b1 || busy !== 1'b1 || credit !== 10'd50)
      begin n_fail++; $display("FAIL cancel_and_coin: got rej %b busy %b credit %0d, expected 1 1 50", coin_reject, busy, credit); end
    n_tests++; if (chg_valid !== 1'b1 || chg_sel !== 3'd3)
      begin n_fail++; $display("FAIL chg_present: got valid %b sel %0d, expected 1 3", chg_valid, chg_sel); end
    coin(3'd1);
    n_tests++; if (coin_reject !== 1'b1 || credit !== 10'd50)
      begin n_fail++; $display("FAIL coin_in_change: got rej %b credit %0d, expected 1 50", coin_reject, credit); end
    sel(4'd0);
    n_tests++; if (busy !== 1'b1 || disp_val !== 10'd50)
      begin n_fail++; $display("FAIL sel_in_change: got busy %b disp %0d, expected 1 50", busy, disp_val); end
    chg_ready = 1'b1;
    wait_idle(50);
    n_tests++; if (busy !== 1'b0 || credit !== '0 || exp_chg_q.size() != 0)
      begin n_fail++; $display("FAIL cancel_coin_done: got busy %b credit %0d left %0d, expected 0 0 0", busy, credit, exp_chg_q.size()); end
  endtask

  task automatic test_back_to_back();
    cfg_we = 1'b1; cfg_idx = 4'd1; cfg_price = 10'd30; cfg_stock = 4'd1;
    tick();
    cfg_we = 1'b0;
    n_tests++; if (oos !== '0) begin n_fail++; $display("FAIL cfg_write: got oos %b, expected 0", oos); end
    coin(3'd2); coin(3'd1);
    n_tests++; if (avail !== 9'b000000010) begin n_fail++; $display("FAIL avail_35: got %b, expected 000000010", avail); end
    exp_vend_q.push_back(1);
    exp_chg_q.push_back(0);
    sel(4'd1);
    wait_idle(50);
    n_tests++; if (credit !== '0 || oos !== 9'b000000010)
      begin n_fail++; $display("FAIL last_stock: got credit %0d oos %b, expected 0 000000010", credit, oos); end
    coin(3'd4);
    exp_vend_q.push_back(0);
    sel(4'd0);
    wait_idle(50);
    n_tests++; if (busy !== 1'b0 || credit !== '0 || disp_val !== '0)
      begin n_fail++; $display("FAIL exact_vend: got busy %b credit %0d disp %0d, expected 0 0 0", busy, credit, disp_val); end
    coin(3'd1);
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_price = 10'd5; cfg_stock = 4'd3;
    tick();
    cfg_we = 1'b0;
    n_tests++; if (avail !== '0) begin n_fail++; $display("FAIL cfg_with_credit: got avail %b, expected 0", avail); end
    exp_chg_q.push_back(1);
    do_cancel();
    wait_idle(50);
    n_tests++; if (credit !== '0 || exp_vend_q.size() != 0 || exp_chg_q.size() != 0)
      begin n_fail++; $display("FAIL b2b_done: got credit %0d left %0d/%0d, expected 0 0/0", credit, exp_vend_q.size(), exp_chg_q.size()); end
  endtask

  task automatic test_timeout();
    int n;
    coin(3'd1);
`ifdef VENDING_AUTO_RETURN_EN
    n = 0;
    exp_chg_q.push_back(1);
    while (!chg_valid && n < 100) begin
      tick();
      n++;
    end
    n_tests++; if (n != 20) begin n_fail++; $display("FAIL auto_return: got %0d cycles, expected 20", n); end
`else
    n = 0;
    repeat (100) tick();
    n_tests++; if (credit !== 10'd10 || busy !== 1'b0)
      begin n_fail++; $display("FAIL credit_held: got credit %0d busy %b, expected 10 0", credit, busy); end
    exp_chg_q.push_back(1);
    do_cancel();
`endif
    wait_idle(50);
    n_tests++; if (credit !== '0 || exp_chg_q.size() != 0)
      begin n_fail++; $display("FAIL timeout_done: got credit %0d left %0d, expected 0 0", credit, exp_chg_q.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vend();
    test_max_credit();
    test_shortfall();
    test_cancel_coin();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
